// File: rtl/sensor_pkg.sv
// sensor_pkg
// Shared definitions for the sensor sampling controller: FSM state encoding
// (also exported on state_dbg), default parameter values and a counter-width
// helper.
package sensor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CONVERT = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   localparam int DEF_DATA_W         = 8;
   localparam int DEF_AVG_LOG2       = 2;
   localparam int DEF_SETTLE_CYCLES  = 4;
   localparam int DEF_PERIOD_CYCLES  = 64;
   localparam int DEF_TIMEOUT_CYCLES = 32;
   localparam int DEF_HYST           = 4;

   // Width of a counter that must hold the value n-1 (at least 1 bit).
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sensor_avg_alarm.sv
// sensor_avg_alarm
// Burst accumulator, shift-average and hysteretic threshold alarm.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   accept         : sample strobe; add sample into the accumulator
//   publish        : final sample of a burst (implies accept); publish the
//                    average, pulse avg_valid, update alarm, clear acc
//   discard        : drop the partial burst (clear acc)
//   sample         : raw sample, zero-extended into acc
//   threshold      : alarm set level, used on publish
//   avg_out        : last published average (held)
//   avg_valid      : one-cycle strobe with each publish
//   alarm          : hysteretic alarm level
module sensor_avg_alarm
   import sensor_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int AVG_LOG2 = DEF_AVG_LOG2,
   parameter int HYST     = DEF_HYST
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              accept,
   input  logic              publish,
   input  logic              discard,
   input  logic [DATA_W-1:0] sample,
   input  logic [DATA_W-1:0] threshold,
   output logic [DATA_W-1:0] avg_out,
   output logic              avg_valid,
   output logic              alarm
);

   localparam int ACC_W = DATA_W + AVG_LOG2;

   logic [ACC_W-1:0]  acc_q, acc_d, sum;
   logic [DATA_W-1:0] avg_q, avg_d, avg_new;
   logic              avg_valid_q, avg_valid_d;
   logic              alarm_q, alarm_d;
   logic [DATA_W:0]   clr_lvl;
   logic              set_hit, clr_hit;

   always_comb begin
      sum     = acc_q + ACC_W'(sample);
      // Average of the completed burst includes the sample arriving now.
      avg_new = sum[AVG_LOG2 +: DATA_W];
      // Clear level in one extra bit; a borrow means threshold < HYST and
      // the alarm can then never clear.
      clr_lvl = {1'b0, threshold} - (DATA_W+1)'(HYST);
      set_hit = (avg_new >= threshold);
      clr_hit = !clr_lvl[DATA_W] && ({1'b0, avg_new} < clr_lvl);

      acc_d       = acc_q;
      avg_d       = avg_q;
      avg_valid_d = 1'b0;
      alarm_d     = alarm_q;
      if (publish) begin
         acc_d       = '0;
         avg_d       = avg_new;
         avg_valid_d = 1'b1;
         if (set_hit)      alarm_d = 1'b1;
         else if (clr_hit) alarm_d = 1'b0;
      end else if (accept) begin
         acc_d = sum;
      end else if (discard) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         avg_q       <= avg_d;
         avg_valid_q <= avg_valid_d;
         alarm_q     <= alarm_d;
      end
   end

   assign avg_out   = avg_q;
   assign avg_valid = avg_valid_q;
   assign alarm     = alarm_q;

endmodule

// File: rtl/sensor_sample_ctrl.sv
// sensor_sample_ctrl
// Periodic burst sampler: IDLE period wait, SETTLE wait, conversion trigger,
// result collection with timeout; after 2^AVG_LOG2 samples the average is
// published and the threshold alarm updated.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   enable       : allows new bursts to start (does not abort a running one)
//   threshold    : alarm set level
//   sens_data    : raw sample, valid with sens_valid
//   sens_valid   : conversion result strobe
//   sens_start   : one-cycle conversion trigger
//   avg_out      : last published average
//   avg_valid    : one-cycle strobe on avg_out update
//   alarm        : hysteretic alarm
//   timeout_err  : sticky conversion-timeout flag
//   state_dbg    : current FSM state
module sensor_sample_ctrl
   import sensor_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int AVG_LOG2       = DEF_AVG_LOG2,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int HYST           = DEF_HYST
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [DATA_W-1:0] threshold,
   input  logic [DATA_W-1:0] sens_data,
   input  logic              sens_valid,
   output logic              sens_start,
   output logic [DATA_W-1:0] avg_out,
   output logic              avg_valid,
   output logic              alarm,
   output logic              timeout_err,
   output logic [1:0]        state_dbg
);

   localparam int PCNT_W = cnt_w(PERIOD_CYCLES);
   localparam int SCNT_W = cnt_w(SETTLE_CYCLES);
   localparam int TCNT_W = cnt_w(TIMEOUT_CYCLES);
   localparam int NCNT_W = AVG_LOG2 + 1;

   localparam logic [PCNT_W-1:0] P_LAST    = PCNT_W'(PERIOD_CYCLES - 1);
   localparam logic [SCNT_W-1:0] S_LAST    = SCNT_W'(SETTLE_CYCLES - 1);
   localparam logic [TCNT_W-1:0] T_LAST    = TCNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [NCNT_W-1:0] N_SAMPLES = NCNT_W'(1 << AVG_LOG2);

   state_e            state_q, state_d;
   logic [PCNT_W-1:0] pcnt_q, pcnt_d;
   logic [SCNT_W-1:0] scnt_q, scnt_d;
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;
   logic [NCNT_W-1:0] ncnt_q, ncnt_d, ncnt_inc;
   logic              sens_start_q, sens_start_d;
   logic              timeout_err_q, timeout_err_d;
   logic              accept, publish, discard;

   always_comb begin
      state_d       = state_q;
      pcnt_d        = pcnt_q;
      scnt_d        = scnt_q;
      tcnt_d        = tcnt_q;
      ncnt_d        = ncnt_q;
      ncnt_inc      = ncnt_q + NCNT_W'(1);
      sens_start_d  = 1'b0;
      timeout_err_d = timeout_err_q;
      accept        = 1'b0;
      publish       = 1'b0;
      discard       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Counter parks at its terminal value while disabled so the
            // burst starts as soon as enable returns.
            if (pcnt_q == P_LAST) begin
               if (enable) begin
                  state_d = ST_SETTLE;
                  scnt_d  = '0;
               end
            end else begin
               pcnt_d = pcnt_q + PCNT_W'(1);
            end
         end
         ST_SETTLE: begin
            if (scnt_q == S_LAST) begin
               sens_start_d = 1'b1;
               state_d      = ST_CONVERT;
               tcnt_d       = '0;
            end else begin
               scnt_d = scnt_q + SCNT_W'(1);
            end
         end
         ST_CONVERT: begin
            // A valid on the expiry cycle is accepted, so it is tested first.
            if (sens_valid) begin
               accept = 1'b1;
               ncnt_d = ncnt_inc;
               if (ncnt_inc == N_SAMPLES) begin
                  publish = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SETTLE;
                  scnt_d  = '0;
               end
            end else if (tcnt_q == T_LAST) begin
               timeout_err_d = 1'b1;
               discard       = 1'b1;
               ncnt_d        = '0;
               pcnt_d        = '0;
               state_d       = ST_IDLE;
            end else begin
               tcnt_d = tcnt_q + TCNT_W'(1);
            end
         end
         ST_DONE: begin
            ncnt_d  = '0;
            pcnt_d  = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         pcnt_q        <= '0;
         scnt_q        <= '0;
         tcnt_q        <= '0;
         ncnt_q        <= '0;
         sens_start_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pcnt_q        <= pcnt_d;
         scnt_q        <= scnt_d;
         tcnt_q        <= tcnt_d;
         ncnt_q        <= ncnt_d;
         sens_start_q  <= sens_start_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   sensor_avg_alarm #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2),
      .HYST     (HYST)
   ) u_avg (
      .clk       (clk),
      .rst_n     (rst_n),
      .accept    (accept),
      .publish   (publish),
      .discard   (discard),
      .sample    (sens_data),
      .threshold (threshold),
      .avg_out   (avg_out),
      .avg_valid (avg_valid),
      .alarm     (alarm)
   );

   assign sens_start  = sens_start_q;
   assign timeout_err = timeout_err_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_sensor_sample_ctrl.sv
module tb_sensor_sample_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, enable;
   logic [7:0] threshold, sens_data;
   logic       sens_valid;
   logic       sens_start, avg_valid, alarm, timeout_err;
   logic [7:0] avg_out;
   logic [1:0] state_dbg;

   sensor_sample_ctrl dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .threshold(threshold),
      .sens_data(sens_data), .sens_valid(sens_valid), .sens_start(sens_start),
      .avg_out(avg_out), .avg_valid(avg_valid), .alarm(alarm),
      .timeout_err(timeout_err), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- datapath model ----------------
   logic [7:0] resp_q[$];
   int         lat = 3;

   initial begin
      logic [7:0] d;
      sens_valid = 1'b0;
      sens_data  = 8'd0;
      forever begin
         @(negedge clk);
         if (sens_start && resp_q.size() != 0) begin
            d = resp_q.pop_front();
            repeat (lat - 1) @(negedge clk);
            sens_valid = 1'b1;
            sens_data  = d;
            @(negedge clk);
            sens_valid = 1'b0;
         end
      end
   end

   // ---------------- monitors ----------------
   int         n_start = 0;
   int         n_avg = 0;
   logic       last_sv = 1'b0;
   logic [1:0] hist[5];

   initial forever begin
      @(posedge clk);
      last_sv = sens_valid;
   end

   initial begin
      for (int i = 0; i < 5; i++) hist[i] = 2'd0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (sens_start) begin
               n_start++;
               // exactly SETTLE_CYCLES settle cycles right before the trigger
               chk("settle_window",
                   (hist[0] == 2'd1 && hist[1] == 2'd1 && hist[2] == 2'd1 &&
                    hist[3] == 2'd1 && hist[4] != 2'd1), 1);
               chk("start_in_convert", state_dbg, 2);
            end
            if (avg_valid) begin
               n_avg++;
               chk("avg_valid_after_valid", last_sv, 1);
            end
         end
         for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = state_dbg;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic do_reset();
      rst_n     = 1'b0;
      threshold = 8'd200;
      lat       = 3;
      resp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // posedges until sens_start is seen (checked #1 after each edge)
   task automatic wait_start(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!sens_start && cyc < 400);
      if (!sens_start) chk("start_wait", 0, 1);
   endtask

   task automatic wait_avg(output bit got);
      int k = 0;
      got = 0;
      while (!avg_valid && k < 800) begin
         @(negedge clk);
         k++;
      end
      got = avg_valid;
      if (!got) chk("avg_wait", 0, 1);
   endtask

   task automatic run_burst(input string nm, input logic [7:0] thr, input logic [31:0] smp,
                            input int l, input logic [7:0] e_avg, input logic e_alarm);
      bit got;
      int ns0;
      threshold = thr;
      lat = l;
      for (int i = 0; i < 4; i++) resp_q.push_back(smp[8*i +: 8]);
      ns0 = n_start;
      wait_avg(got);
      if (got) begin
         chk({nm, "_avg"}, avg_out, e_avg);
         chk({nm, "_alarm"}, alarm, e_alarm);
         chk({nm, "_starts"}, n_start - ns0, 4);
      end
      @(negedge clk);
      chk({nm, "_vld_pulse"}, avg_valid, 0);
   endtask

   // ---------------- vectors ----------------
   typedef struct packed {
      logic [7:0]  thr;
      logic [31:0] smp;
      logic [7:0]  exp_avg;
      logic        exp_alarm;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int  cyc, ns0, na0;
      bit  got;
      int  base, s, sum, avg, thr, m_alarm;
      logic [31:0] smp;

      tbl[0]  = '{8'd25,  {8'd25, 8'd25, 8'd25, 8'd25},     8'd25,  1'b1}; // set at equality
      tbl[1]  = '{8'd25,  {8'd21, 8'd23, 8'd22, 8'd22},     8'd22,  1'b1}; // hold in band
      tbl[2]  = '{8'd25,  {8'd20, 8'd19, 8'd21, 8'd20},     8'd20,  1'b0}; // clear below thr-HYST
      tbl[3]  = '{8'd25,  {8'd21, 8'd21, 8'd21, 8'd21},     8'd21,  1'b0}; // at clear level: hold
      tbl[4]  = '{8'd25,  {8'd2, 8'd1, 8'd1, 8'd1},         8'd1,   1'b0}; // truncating average
      tbl[5]  = '{8'd0,   {8'd0, 8'd0, 8'd0, 8'd0},         8'd0,   1'b1}; // zero threshold
      tbl[6]  = '{8'd3,   {8'd0, 8'd0, 8'd0, 8'd0},         8'd0,   1'b1}; // thr < HYST: never clear
      tbl[7]  = '{8'd4,   {8'd0, 8'd0, 8'd0, 8'd0},         8'd0,   1'b1}; // clear level 0: hold
      tbl[8]  = '{8'd5,   {8'd3, 8'd0, 8'd0, 8'd0},         8'd0,   1'b0}; // 0 < 1: clear
      tbl[9]  = '{8'd255, {8'd255, 8'd255, 8'd255, 8'd255}, 8'd255, 1'b1}; // full scale
      tbl[10] = '{8'd255, {8'd252, 8'd251, 8'd250, 8'd250}, 8'd250, 1'b0};

      enable    = 1'b1;
      threshold = 8'd200;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_state", state_dbg, 0);
      chk("rst_start", sens_start, 0);
      chk("rst_avg", avg_out, 0);
      chk("rst_avg_valid", avg_valid, 0);
      chk("rst_alarm", alarm, 0);
      chk("rst_timeout", timeout_err, 0);

      // first burst: 10,20,30,40 with 3-cycle latency
      resp_q = '{8'd10, 8'd20, 8'd30, 8'd40};
      lat = 3;
      ns0 = n_start;
      rst_n = 1'b1;
      wait_start(cyc);
      chk("first_start_latency", cyc, 68);
      wait_avg(got);
      if (got) begin
         chk("first_avg", avg_out, 25);
         chk("first_alarm", alarm, 0);
      end
      @(negedge clk);
      chk("first_vld_pulse", avg_valid, 0);
      chk("first_avg_held", avg_out, 25);
      chk("first_starts", n_start - ns0, 4);
      chk("first_avg_count", n_avg, 1);

      // table-driven bursts (alarm history carries row to row)
      for (int r = 0; r < 11; r++)
         run_burst($sformatf("row%0d", r), tbl[r].thr, tbl[r].smp, 2 + r,
                   tbl[r].exp_avg, tbl[r].exp_alarm);

      // randomized bursts against a plain-arithmetic model
      m_alarm = 0;
      for (int r = 0; r < 10; r++) begin
         base = $urandom_range(0, 255);
         sum = 0;
         for (int i = 0; i < 4; i++) begin
            s = base + $urandom_range(0, 8) - 4;
            if (s < 0) s = 0;
            if (s > 255) s = 255;
            smp[8*i +: 8] = 8'(s);
            sum += s;
         end
         avg = sum / 4;
         thr = avg + $urandom_range(0, 12) - 6;
         if (thr < 0) thr = 0;
         if (thr > 255) thr = 255;
         if (avg >= thr) m_alarm = 1;
         else if (avg < thr - 4) m_alarm = 0;
         run_burst($sformatf("rnd%0d", r), 8'(thr), smp, $urandom_range(1, 12),
                   8'(avg), m_alarm[0]);
      end

      // datapath never answers: timeout after 32 CONVERT cycles
      do_reset();
      wait_start(cyc);
      na0 = n_avg;
      repeat (31) @(posedge clk);
      #1;
      chk("to_not_yet", timeout_err, 0);
      chk("to_still_convert", state_dbg, 2);
      @(posedge clk);
      #1;
      chk("to_set", timeout_err, 1);
      chk("to_idle", state_dbg, 0);
      run_burst("after_to", 8'd200, {8'd104, 8'd100, 8'd100, 8'd100}, 3, 8'd101, 1'b0);
      chk("to_sticky", timeout_err, 1);
      chk("to_no_partial_avg", n_avg - na0, 1);

      // valid on the 32nd CONVERT cycle is accepted
      do_reset();
      run_burst("edge32", 8'd200, {8'd7, 8'd7, 8'd7, 8'd7}, 32, 8'd7, 1'b0);
      chk("edge32_no_err", timeout_err, 0);

      // valid one cycle late: timeout, late valid ignored in IDLE
      resp_q.push_back(8'd9);
      lat = 33;
      na0 = n_avg;
      wait_start(cyc);
      repeat (40) @(negedge clk);
      chk("late33_err", timeout_err, 1);
      chk("late33_idle", state_dbg, 0);
      chk("late33_no_avg", n_avg, na0);
      run_burst("after_late", 8'd200, {8'd40, 8'd40, 8'd40, 8'd40}, 3, 8'd40, 1'b0);

      // enable dropped during the 2nd sample
      do_reset();
      enable = 1'b1;
      resp_q = '{8'd50, 8'd50, 8'd50, 8'd50, 8'd60, 8'd60, 8'd60, 8'd60};
      wait_start(cyc);
      wait_start(cyc);
      enable = 1'b0;
      wait_avg(got);
      if (got) chk("en_drop_avg", avg_out, 50);
      ns0 = n_start;
      repeat (150) @(negedge clk);
      chk("en_drop_no_start", n_start, ns0);
      chk("en_drop_idle", state_dbg, 0);
      enable = 1'b1;
      @(posedge clk);
      #1;
      chk("en_return_settle", state_dbg, 1);
      wait_avg(got);
      if (got) chk("en_return_avg", avg_out, 60);
      @(negedge clk);

      // async reset in CONVERT, stale valid after release
      resp_q = '{8'd70, 8'd80, 8'd80, 8'd80, 8'd80};
      lat = 6;
      wait_start(cyc);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_state", state_dbg, 0);
      chk("arst_start", sens_start, 0);
      chk("arst_avg", avg_out, 0);
      chk("arst_alarm", alarm, 0);
      chk("arst_timeout", timeout_err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_start(cyc);
      chk("arst_restart_latency", cyc, 68);
      wait_avg(got);
      if (got) chk("arst_avg_after", avg_out, 80);
      chk("arst_queue_drained", resp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sensor_sample_ctrl.md
# sensor_sample_ctrl

Sampling controller for the sensor tile (`tt_um_roy1707018_sensor`). It runs periodic measurement bursts on the sensor datapath: settle, then trigger a conversion, then collect the result. After each burst of 2^AVG_LOG2 samples it averages them, publishes the average, and drives a hysteretic threshold alarm. It sits between the tile's `ui_in`/`uo_out` pin mapping and the raw sensor datapath; the datapath holds no sequencing logic of its own.

## Interface
Parameters:
- `DATA_W`, 8: sample width.
- `AVG_LOG2`, 2: log2 of samples per burst (range 0..4).
- `SETTLE_CYCLES`, 4: settle wait before each conversion trigger (at least 1).
- `PERIOD_CYCLES`, 64: idle cycles between bursts (at least 1).
- `TIMEOUT_CYCLES`, 32: maximum wait for `sens_valid` per conversion.
- `HYST`, 4: alarm clear hysteresis, in LSBs.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `enable`, in, 1: level; allows new bursts to start.
- `threshold`, in, DATA_W: alarm set level; sampled at burst completion.
- `sens_data`, in, DATA_W: raw sample from the datapath; valid with `sens_valid`.
- `sens_valid`, in, 1: one-cycle strobe; conversion result present.
- `sens_start`, out, 1: one-cycle conversion trigger to the datapath.
- `avg_out`, out, DATA_W: last published average; held between bursts.
- `avg_valid`, out, 1: one-cycle strobe when `avg_out` updates.
- `alarm`, out, 1: hysteretic threshold alarm level.
- `timeout_err`, out, 1: sticky; set on any conversion timeout.
- `state_dbg`, out, 2: current FSM state encoding.

## Operation
- FSM states (2-bit encoding):
  - IDLE = 0: period counter runs. Leave for SETTLE when the counter reaches PERIOD_CYCLES−1 and `enable` = 1. If `enable` = 0, hold the counter at its terminal value, so the burst starts on the first cycle `enable` rises.
  - SETTLE = 1: count SETTLE_CYCLES. On the last settle cycle, register `sens_start` = 1 and move to CONVERT.
  - CONVERT = 2: wait for `sens_valid`.
    - On `sens_valid`: acc += zero-extended `sens_data`, and sample count increments.
    - If the count reaches 2^AVG_LOG2, go to DONE; otherwise return to SETTLE.
    - Timeout: if `sens_valid` is not seen within TIMEOUT_CYCLES, set `timeout_err`, discard the partial burst (acc and count cleared), and go to IDLE.
  - DONE = 3: for one cycle, `avg_out` ← acc >> AVG_LOG2 (truncating), `avg_valid` = 1, then update `alarm`. Clear acc, count and the period counter, and go to IDLE.
- Accumulator width is DATA_W+AVG_LOG2; it cannot overflow.
- Alarm update (in DONE only), using the new average `avg`:
  - Set if `avg` ≥ `threshold`.
  - Clear if `avg` < `threshold` − HYST. Compute this in DATA_W+1 bits; when `threshold` < HYST, the clear condition is never true.
  - Otherwise hold.
- Dropping `enable` mid-burst does not abort the burst; it only blocks the next one.
- `sens_valid` outside CONVERT is ignored.
- `timeout_err` is cleared only by reset.

## Timing
- Reset values: FSM = IDLE; all counters, acc, `avg_out`, `avg_valid`, `sens_start`, `alarm` and `timeout_err` = 0.
- An asynchronous reset mid-burst returns the block to IDLE immediately, and the period restarts from 0.
- All outputs are registered.
- `sens_start` rises SETTLE_CYCLES cycles after entering SETTLE.
- The CONVERT timeout counter starts at 0 on the cycle after `sens_start`.
- `sens_valid` on the same cycle as timeout expiry: the valid wins (sample accepted, no error).
- `avg_valid` asserts the cycle after the final `sens_valid` is accepted. `alarm` updates in that same cycle.
- The first burst starts PERIOD_CYCLES cycles after reset release, provided `enable` = 1.

## Structure
- Shared package `sensor_pkg`: FSM state typedef/encoding (also used by `state_dbg` decode in the top level) and the default parameter constants.
- One sub-module, `sensor_avg_alarm`: accumulator, shift-average and hysteresis comparator, driven by accept/publish strobes from the FSM.
- The FSM and the three counters (period, settle, timeout) live in `sensor_sample_ctrl`.

## Test plan
- Defaults, `enable` = 1, datapath model returning 10, 20, 30, 40 with 3-cycle latency → one `avg_valid` with `avg_out` = 25; exactly 4 `sens_start` pulses, each preceded by 4 settle cycles.
- `threshold` = 25, averages 25 then 22 then 20 → `alarm` goes 1, stays 1 (22 ≥ 21), then 0 (20 < 21).
- Datapath never responds → after 32 cycles in CONVERT, `timeout_err` = 1, FSM back in IDLE, no `avg_valid`; the next burst completes normally while `timeout_err` stays 1.
- `sens_valid` on exactly the 32nd CONVERT cycle → sample accepted, `timeout_err` stays 0.
- `enable` dropped during the 2nd sample → burst completes with `avg_valid`; no new `sens_start` until `enable` returns, then SETTLE is entered on the first cycle `enable` = 1.
- `rst_n` pulsed low during CONVERT → all outputs 0 immediately; a stale `sens_valid` after release is ignored, and the first `sens_start` occurs 64+4 cycles later.
